// File: rtl/rib_timer_pkg.sv
// rib_timer_pkg: shared bus widths, timer register offsets, CTRL layout and
// reset constants for the RIB timer slave.
// Optional prescaler is selected by RIB_TIMER_PRESCALER_EN (see rib_timer.sv).
package rib_timer_pkg;

  localparam int unsigned BUS_ADDR_WIDTH = 32;
  localparam int unsigned BUS_DATA_WIDTH = 32;

  localparam logic [BUS_DATA_WIDTH-1:0] ZERO_WORD     = '0;
  localparam logic                      WRITE_ENABLE  = 1'b1;
  localparam logic                      WRITE_DISABLE = 1'b0;

  // Register offsets within the decoded address window
  localparam logic [BUS_ADDR_WIDTH-1:0] TIMER_CTRL     = 32'h0000_0000;
  localparam logic [BUS_ADDR_WIDTH-1:0] TIMER_COUNT    = 32'h0000_0004;
  localparam logic [BUS_ADDR_WIDTH-1:0] TIMER_VALUE    = 32'h0000_0008;
  localparam logic [BUS_ADDR_WIDTH-1:0] TIMER_PRESCALE = 32'h0000_000C;

  // CTRL bit indices
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IE      = 1;
  localparam int unsigned CTRL_PEND    = 2;
  localparam int unsigned CTRL_ONESHOT = 3;

  // CTRL register image; member order matches the bit indices above
  typedef struct packed {
    logic oneshot;
    logic pend;
    logic ie;
    logic en;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '0;

  // Zero-extend the CTRL image to a bus word for reads
  function automatic logic [BUS_DATA_WIDTH-1:0] ctrl_word(input ctrl_t c);
    return BUS_DATA_WIDTH'(c);
  endfunction

endpackage

// File: rtl/rib_timer_prescaler.sv
// rib_timer_prescaler: clock divider producing the timer tick.
// Ports:
//   clk, rst  - clock, async active-high reset
//   en        - timer enable; divider holds while low
//   clr       - restart divider at 0 (software write to COUNT or PRESCALE)
//   prescale  - divider terminal value; tick every prescale+1 enabled cycles
//   tick_c    - combinational tick, high when enabled and divider expires
module rib_timer_prescaler
  import rib_timer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  input  logic [BUS_DATA_WIDTH-1:0] prescale,
  output logic                      tick_c
);

  logic [BUS_DATA_WIDTH-1:0] div;
  logic                      expire;

  assign expire = (div == prescale);
  assign tick_c = en & expire;

  // Divider counts 0..prescale while enabled, restarts on software clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= ZERO_WORD;
    end else if (clr) begin
      div <= ZERO_WORD;
    end else if (en) begin
      div <= expire ? ZERO_WORD : div + BUS_DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/rib_timer.sv
// rib_timer: RIB slave memory-mapped 32-bit timer with compare interrupt.
// Register map (addr_i[ADDR_DEC_BITS-1:0], aliased above that):
//   0x00 CTRL  {ONESHOT, PEND(W1C), IE, EN}
//   0x04 COUNT
//   0x08 VALUE (compare)
//   0x0C PRESCALE (only with RIB_TIMER_PRESCALER_EN defined, else reads 0)
// Ports:
//   clk, rst   - clock, async active-high reset
//   addr_i     - byte address from interconnect
//   data_i     - write data
//   data_o     - combinational read data for addr_i
//   we_i       - write strobe, sampled at posedge clk
//   int_sig_o  - level interrupt, PEND & IE
// Macro: RIB_TIMER_PRESCALER_EN enables the PRESCALE register and divider.
module rib_timer
  import rib_timer_pkg::*;
#(
  parameter int unsigned ADDR_DEC_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BUS_ADDR_WIDTH-1:0] addr_i,
  input  logic [BUS_DATA_WIDTH-1:0] data_i,
  output logic [BUS_DATA_WIDTH-1:0] data_o,
  input  logic                      we_i,
  output logic                      int_sig_o
);

  ctrl_t                     ctrl;
  logic [BUS_DATA_WIDTH-1:0] count;
  logic [BUS_DATA_WIDTH-1:0] value;
  logic [BUS_DATA_WIDTH-1:0] prescale;
  logic [BUS_ADDR_WIDTH-1:0] offset;
  logic                      unused_addr;
  logic                      wr_ctrl;
  logic                      wr_count;
  logic                      wr_value;
  logic                      tick;
  logic                      match;

  // Upper address bits are deliberately ignored so the map aliases
  assign offset      = BUS_ADDR_WIDTH'(addr_i[ADDR_DEC_BITS-1:0]);
  assign unused_addr = ^(addr_i >> ADDR_DEC_BITS);

  assign wr_ctrl  = (we_i == WRITE_ENABLE) && (offset == TIMER_CTRL);
  assign wr_count = (we_i == WRITE_ENABLE) && (offset == TIMER_COUNT);
  assign wr_value = (we_i == WRITE_ENABLE) && (offset == TIMER_VALUE);

`ifdef RIB_TIMER_PRESCALER_EN
  logic wr_prescale;

  assign wr_prescale = (we_i == WRITE_ENABLE) && (offset == TIMER_PRESCALE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= ZERO_WORD;
    end else if (wr_prescale) begin
      prescale <= data_i;
    end
  end

  rib_timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl.en),
    .clr      (wr_count | wr_prescale),
    .prescale (prescale),
    .tick_c   (tick)
  );
`else
  assign prescale = ZERO_WORD;
  assign tick     = ctrl.en;
`endif

  // Compare hit; VALUE=0 keeps the timer inert
  assign match = tick && (value != ZERO_WORD) && (count == value);

  // Counter and CTRL update. Statement order encodes collision priority:
  // software COUNT/EN writes override the tick, hardware PEND set overrides W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl  <= CTRL_RESET;
      count <= ZERO_WORD;
      value <= ZERO_WORD;
    end else begin
      if (tick) begin
        if (value == ZERO_WORD || count == value) begin
          count <= ZERO_WORD;
        end else begin
          count <= count + BUS_DATA_WIDTH'(1);
        end
      end
      if (wr_count) begin
        count <= data_i;
      end
      if (wr_value) begin
        value <= data_i;
      end
      if (wr_ctrl) begin
        ctrl.en      <= data_i[CTRL_EN];
        ctrl.ie      <= data_i[CTRL_IE];
        ctrl.oneshot <= data_i[CTRL_ONESHOT];
        if (data_i[CTRL_PEND]) begin
          ctrl.pend <= 1'b0;
        end
      end else if (match && ctrl.oneshot) begin
        ctrl.en <= 1'b0;
      end
      if (match) begin
        ctrl.pend <= 1'b1;
      end
    end
  end

  // Zero-latency read mux
  always_comb begin
    data_o = ZERO_WORD;
    case (offset)
      TIMER_CTRL:     data_o = ctrl_word(ctrl);
      TIMER_COUNT:    data_o = count;
      TIMER_VALUE:    data_o = value;
      TIMER_PRESCALE: data_o = prescale;
      default:        data_o = ZERO_WORD;
    endcase
  end

  assign int_sig_o = ctrl.pend & ctrl.ie;

endmodule

// File: tb/tb_rib_timer.sv
// tb_rib_timer: directed self-checking bench for rib_timer.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_rib_timer;
  import rib_timer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        we_i;
  logic        int_sig_o;

  int checks = 0;
  int errors = 0;

  rib_timer #(.ADDR_DEC_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .we_i      (we_i),
    .int_sig_o (int_sig_o)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_i = a;
    #1;
    chk(tag, data_o, exp);
  endtask

  task automatic irq(input string tag, input logic exp);
    chk(tag, 32'(int_sig_o), 32'(exp));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_i = a;
    data_i = d;
    we_i   = 1'b1;
    @(negedge clk);
    we_i   = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    we_i   = 1'b0;
    addr_i = '0;
    data_i = '0;
    cyc(2);
    rd("rst_data_o", TIMER_CTRL, 32'h0);
    irq("rst_int", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Post-reset register state
    rd("init_ctrl", TIMER_CTRL, 32'h0);
    rd("init_count", TIMER_COUNT, 32'h0);
    rd("init_value", TIMER_VALUE, 32'h0);
    rd("init_prescale", TIMER_PRESCALE, 32'h0);

    // Periodic: VALUE=3, EN|IE
    wr(TIMER_VALUE, 32'd3);
    wr(TIMER_CTRL, 32'h3);
    rd("per_count0", TIMER_COUNT, 32'd0);
    cyc(1); rd("per_count1", TIMER_COUNT, 32'd1);
    cyc(1); rd("per_count2", TIMER_COUNT, 32'd2);
    cyc(1); rd("per_count3", TIMER_COUNT, 32'd3);
    rd("per_nopend", TIMER_CTRL, 32'h3);
    irq("per_int_low", 1'b0);
    cyc(1); rd("per_count_wrap", TIMER_COUNT, 32'd0);
    rd("per_pend", TIMER_CTRL, 32'h7);
    irq("per_int_high", 1'b1);
    cyc(1); rd("per_count_next", TIMER_COUNT, 32'd1);

    // Asynchronous reset mid-count with COUNT=0x10 and interrupt active
    wr(TIMER_CTRL, 32'h0);
    wr(TIMER_VALUE, 32'h100);
    wr(TIMER_COUNT, 32'h10);
    wr(TIMER_CTRL, 32'h3);
    rd("pre_rst_count", TIMER_COUNT, 32'h10);
    irq("pre_rst_int", 1'b1);
    rst = 1'b1;
    rd("arst_count", TIMER_COUNT, 32'h0);
    rd("arst_ctrl", TIMER_CTRL, 32'h0);
    rd("arst_value", TIMER_VALUE, 32'h0);
    irq("arst_int", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot: VALUE=2, ONESHOT|IE|EN
    wr(TIMER_VALUE, 32'd2);
    wr(TIMER_CTRL, 32'hB);
    cyc(2); rd("os_count2", TIMER_COUNT, 32'd2);
    rd("os_ctrl_run", TIMER_CTRL, 32'hB);
    cyc(1); rd("os_count_wrap", TIMER_COUNT, 32'd0);
    rd("os_ctrl_done", TIMER_CTRL, 32'hE);
    irq("os_int", 1'b1);
    cyc(3); rd("os_count_stopped", TIMER_COUNT, 32'd0);
    wr(TIMER_CTRL, 32'h4);
    rd("w1c_ctrl", TIMER_CTRL, 32'h0);
    irq("w1c_int", 1'b0);

    // Collisions: W1C on the match edge, COUNT write on a tick edge
    wr(TIMER_VALUE, 32'd1);
    wr(TIMER_CTRL, 32'h3);
    cyc(1); rd("col_count1", TIMER_COUNT, 32'd1);
    wr(TIMER_CTRL, 32'h7);
    rd("col_pend_kept", TIMER_CTRL, 32'h7);
    rd("col_count_match", TIMER_COUNT, 32'd0);
    irq("col_int", 1'b1);
    wr(TIMER_CTRL, 32'h7);
    rd("col_w1c_clear", TIMER_CTRL, 32'h3);
    irq("col_int_clear", 1'b0);
    wr(TIMER_COUNT, 32'h55);
    rd("col_sw_count", TIMER_COUNT, 32'h55);
    cyc(1); rd("col_count_inc", TIMER_COUNT, 32'h56);
    wr(TIMER_CTRL, 32'h4);

    // VALUE=0 keeps the timer inert
    wr(TIMER_VALUE, 32'd0);
    wr(TIMER_COUNT, 32'd7);
    rd("v0_count_set", TIMER_COUNT, 32'd7);
    wr(TIMER_CTRL, 32'h3);
    cyc(20);
    rd("v0_count", TIMER_COUNT, 32'd0);
    rd("v0_ctrl", TIMER_CTRL, 32'h3);
    irq("v0_int", 1'b0);

    // COUNT above VALUE wraps through 0xFFFFFFFF without PEND
    wr(TIMER_CTRL, 32'h2);
    wr(TIMER_VALUE, 32'd5);
    wr(TIMER_COUNT, 32'hFFFF_FFFE);
    wr(TIMER_CTRL, 32'h3);
    rd("wrap_start", TIMER_COUNT, 32'hFFFF_FFFE);
    cyc(1); rd("wrap_max", TIMER_COUNT, 32'hFFFF_FFFF);
    cyc(1); rd("wrap_zero", TIMER_COUNT, 32'h0);
    rd("wrap_nopend", TIMER_CTRL, 32'h3);
    irq("wrap_int", 1'b0);
    cyc(5); rd("wrap_count5", TIMER_COUNT, 32'd5);
    rd("wrap_ctrl5", TIMER_CTRL, 32'h3);
    cyc(1); rd("wrap_match", TIMER_COUNT, 32'd0);
    rd("wrap_pend", TIMER_CTRL, 32'h7);

    // Prescaler
    wr(TIMER_CTRL, 32'h4);
    wr(TIMER_COUNT, 32'd0);
    wr(TIMER_VALUE, 32'd1);
`ifdef RIB_TIMER_PRESCALER_EN
    wr(TIMER_PRESCALE, 32'd2);
    rd("ps_readback", TIMER_PRESCALE, 32'd2);
    wr(TIMER_CTRL, 32'h3);
    cyc(5); rd("ps_ctrl5", TIMER_CTRL, 32'h3);
    rd("ps_count5", TIMER_COUNT, 32'd1);
    cyc(1); rd("ps_pend6", TIMER_CTRL, 32'h7);
    rd("ps_count6", TIMER_COUNT, 32'd0);
    wr(TIMER_CTRL, 32'h7);
    rd("ps_w1c", TIMER_CTRL, 32'h3);
    cyc(4); rd("ps_ctrl11", TIMER_CTRL, 32'h3);
    cyc(1); rd("ps_pend12", TIMER_CTRL, 32'h7);
`else
    wr(TIMER_PRESCALE, 32'd7);
    rd("ps_readback", TIMER_PRESCALE, 32'd0);
    wr(TIMER_CTRL, 32'h3);
    cyc(1); rd("ps_ctrl1", TIMER_CTRL, 32'h3);
    rd("ps_count1", TIMER_COUNT, 32'd1);
    cyc(1); rd("ps_pend2", TIMER_CTRL, 32'h7);
    rd("ps_count2", TIMER_COUNT, 32'd0);
    wr(TIMER_CTRL, 32'h7);
    rd("ps_w1c", TIMER_CTRL, 32'h3);
    cyc(1); rd("ps_pend4", TIMER_CTRL, 32'h7);
`endif

    // Address aliasing and unmapped offsets
    rd("alias_value", 32'h0000_0108, 32'd1);
    rd("unmapped_rd", 32'h0000_0010, 32'h0);
    wr(32'h0000_0010, 32'hFFFF_FFFF);
    rd("unmapped_wr", 32'h0000_0010, 32'h0);
    rd("unmapped_value", TIMER_VALUE, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
